// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter sharing one spi_interface master among NUM_REQ register agents.
// Define SPI_ARB_TIMEOUT_EN to add a watchdog that aborts transfers after TIMEOUT_CYCLES.
module spi_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*32-1:0] req_data_out,
    input  logic [NUM_REQ*6-1:0]  req_read_bits,
    input  logic [NUM_REQ*6-1:0]  req_write_bits,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    done,
    output logic [31:0]           rd_data,
    output logic                  err,
    output logic [31:0]           spi_data_out,
    output logic [5:0]            spi_read_bits,
    output logic [5:0]            spi_write_bits,
    output logic                  spi_request_action,
    input  logic                  spi_busy,
    input  logic [31:0]           spi_data_in
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("spi_arbiter: unsupported parameter values");
    end

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        COMPLETE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     winner_q, winner_d;
    logic [IDX_W-1:0]     pick;
    logic [IDX_W:0]       cand;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [31:0]          data_q, data_d;
    logic [31:0]          rd_q, rd_d;
    logic [5:0]           rbits_q, rbits_d;
    logic [5:0]           wbits_q, wbits_d;
    logic                 timeout;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 tout_q, tout_d;
`endif

    // Scan from ptr downward in priority so the first requester at or after ptr wins.
    always_comb begin
        pick = ptr_q;
        cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
                cand = cand - (IDX_W + 1)'(NUM_REQ);
            end
            if (req[cand[IDX_W-1:0]]) begin
                pick = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        grant_d  = grant_q;
        data_d   = data_q;
        rbits_d  = rbits_q;
        wbits_d  = wbits_q;
        rd_d     = rd_q;
        timeout  = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        tout_d   = tout_q;
        timeout  = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
        if (state_q == WAIT_BUSY || state_q == WAIT_DONE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
`endif
        case (state_q)
            IDLE: begin
                if ((|req) && !spi_busy) begin
                    state_d        = LAUNCH;
                    winner_d       = pick;
                    grant_d        = '0;
                    grant_d[pick]  = 1'b1;
                    data_d         = req_data_out[32*pick +: 32];
                    rbits_d        = req_read_bits[6*pick +: 6];
                    wbits_d        = req_write_bits[6*pick +: 6];
                end
            end
            LAUNCH: begin
                state_d = WAIT_BUSY;
`ifdef SPI_ARB_TIMEOUT_EN
                cnt_d   = '0;
                tout_d  = 1'b0;
`endif
            end
            // A transfer that never starts in time is aborted even if busy rises on the last cycle.
            WAIT_BUSY: begin
                if (timeout) begin
                    state_d = COMPLETE;
`ifdef SPI_ARB_TIMEOUT_EN
                    tout_d  = 1'b1;
`endif
                end else if (spi_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!spi_busy) begin
                    rd_d    = spi_data_in;
                    state_d = COMPLETE;
                end else if (timeout) begin
                    state_d = COMPLETE;
`ifdef SPI_ARB_TIMEOUT_EN
                    tout_d  = 1'b1;
`endif
                end
            end
            COMPLETE: begin
                grant_d = '0;
                state_d = IDLE;
                if (winner_q == IDX_W'(NUM_REQ - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = winner_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            winner_q <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            rbits_q  <= '0;
            wbits_q  <= '0;
            rd_q     <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            tout_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            rbits_q  <= rbits_d;
            wbits_q  <= wbits_d;
            rd_q     <= rd_d;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            tout_q   <= tout_d;
`endif
        end
    end

    assign grant              = grant_q;
    assign done               = (state_q == COMPLETE) ? grant_q : '0;
    assign rd_data            = rd_q;
    assign spi_data_out       = data_q;
    assign spi_read_bits      = rbits_q;
    assign spi_write_bits     = wbits_q;
    assign spi_request_action = (state_q == LAUNCH);
`ifdef SPI_ARB_TIMEOUT_EN
    assign err                = (state_q == COMPLETE) && tout_q;
`else
    assign err                = 1'b0;
`endif

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: randomized bench for spi_arbiter checked against a round-robin reference model.
// The watchdog scenario runs only when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_arbiter;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*32-1:0] req_data_out;
    logic [N*6-1:0]  req_read_bits;
    logic [N*6-1:0]  req_write_bits;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic [31:0]     rd_data;
    logic            err;
    logic [31:0]     spi_data_out;
    logic [5:0]      spi_read_bits;
    logic [5:0]      spi_write_bits;
    logic            spi_request_action;
    logic            spi_busy;
    logic [31:0]     spi_data_in;

    int nCompared   = 0;
    int nMismatched = 0;
    int modelPtr    = 0;

    spi_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk                (clk),
        .reset              (reset),
        .req                (req),
        .req_data_out       (req_data_out),
        .req_read_bits      (req_read_bits),
        .req_write_bits     (req_write_bits),
        .grant              (grant),
        .done               (done),
        .rd_data            (rd_data),
        .err                (err),
        .spi_data_out       (spi_data_out),
        .spi_read_bits      (spi_read_bits),
        .spi_write_bits     (spi_write_bits),
        .spi_request_action (spi_request_action),
        .spi_busy           (spi_busy),
        .spi_data_in        (spi_data_in)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: first requesting agent at or after the pointer, wrapping around.
    function automatic int rrPick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic randomizePayloads();
        for (int i = 0; i < N; i++) begin
            req_data_out[32*i +: 32]  = $urandom();
            req_read_bits[6*i +: 6]   = 6'($urandom_range(0, 63));
            req_write_bits[6*i +: 6]  = 6'($urandom_range(0, 63));
        end
    endtask

    // Called at a falling edge with the arbiter idle; runs one full transaction.
    task automatic applyStimulus(input logic [N-1:0] pattern, input int preBusy, input int busyDelay,
                                 input int busyLen, input logic [31:0] din, input bit randPay);
        int          w;
        int          waitCnt;
        logic [31:0] expData;
        logic [5:0]  expRb;
        logic [5:0]  expWb;
        req = pattern;
        if (randPay) randomizePayloads();
        w = rrPick(pattern, modelPtr);
        if (w < 0) w = 0;
        expData = req_data_out[32*w +: 32];
        expRb   = req_read_bits[6*w +: 6];
        expWb   = req_write_bits[6*w +: 6];
        if (preBusy > 0) begin
            spi_busy = 1'b1;
            for (int i = 0; i < preBusy; i++) begin
                @(negedge clk);
                checkOutput("busyIdleGrant", 32'(grant), 32'd0);
            end
            spi_busy = 1'b0;
        end
        waitCnt = 0;
        do begin
            @(negedge clk);
            waitCnt++;
        end while (spi_request_action !== 1'b1 && waitCnt < 8);
        checkOutput("launchLatency", 32'(waitCnt), 32'd1);
        checkOutput("grantWinner", 32'(grant), 32'd1 << w);
        checkOutput("spiDataOut", spi_data_out, expData);
        checkOutput("spiReadBits", 32'(spi_read_bits), 32'(expRb));
        checkOutput("spiWriteBits", 32'(spi_write_bits), 32'(expWb));
        req_data_out[32*w +: 32] = ~expData;
        req_read_bits[6*w +: 6]  = ~expRb;
        @(negedge clk);
        checkOutput("actionPulse", 32'(spi_request_action), 32'd0);
        repeat (busyDelay) @(negedge clk);
        spi_busy = 1'b1;
        repeat (busyLen) @(negedge clk);
        checkOutput("payloadHeld", spi_data_out, expData);
        checkOutput("countHeld", 32'(spi_read_bits), 32'(expRb));
        spi_data_in = din;
        spi_busy    = 1'b0;
        @(negedge clk);
        checkOutput("doneStrobe", 32'(done), 32'd1 << w);
        checkOutput("rdData", rd_data, din);
        checkOutput("errQuiet", 32'(err), 32'd0);
        checkOutput("grantAtDone", 32'(grant), 32'd1 << w);
        modelPtr    = (w + 1) % N;
        req[w]      = 1'b0;
        spi_data_in = $urandom();
        @(negedge clk);
        checkOutput("doneCleared", 32'(done), 32'd0);
        checkOutput("grantCleared", 32'(grant), 32'd0);
        checkOutput("rdHeld", rd_data, din);
    endtask

    initial begin
        logic [N-1:0] pat;
        int           waitCnt;
`ifdef SPI_ARB_TIMEOUT_EN
        int           tw;
        logic [31:0]  prevRd;
`endif
        reset          = 1'b1;
        req            = '0;
        req_data_out   = '0;
        req_read_bits  = '0;
        req_write_bits = '0;
        spi_busy       = 1'b0;
        spi_data_in    = '0;
        repeat (3) @(negedge clk);
        checkOutput("rstGrant", 32'(grant), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstRdData", rd_data, 32'd0);
        checkOutput("rstErr", 32'(err), 32'd0);
        checkOutput("rstSpiData", spi_data_out, 32'd0);
        checkOutput("rstReadBits", 32'(spi_read_bits), 32'd0);
        checkOutput("rstWriteBits", 32'(spi_write_bits), 32'd0);
        checkOutput("rstAction", 32'(spi_request_action), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b1111, 0, $urandom_range(0, 2), $urandom_range(1, 3), $urandom(), 1'b1);
        end

        req_data_out[63:32] = 32'h03F0_0010;
        applyStimulus(4'b0010, 0, 2, 3, 32'h0000_00A5, 1'b0);

        applyStimulus(4'b0100, 0, 0, 1, $urandom(), 1'b1);
        applyStimulus(4'b0001, 2, 1, 2, $urandom(), 1'b1);
        applyStimulus(4'b1001, 0, 1, 1, $urandom(), 1'b1);
        applyStimulus(4'b0001, 0, 0, 2, $urandom(), 1'b1);

        for (int i = 0; i < 24; i++) begin
            pat = req | N'($urandom_range(0, 15));
            if (pat == '0) pat = 4'b0001;
            applyStimulus(pat, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(1, 4),
                          $urandom(), 1'b1);
        end

        // Reset while the transfer is in flight.
        req     = 4'b0100;
        waitCnt = 0;
        do begin
            @(negedge clk);
            waitCnt++;
        end while (spi_request_action !== 1'b1 && waitCnt < 8);
        checkOutput("rstMidLaunch", 32'(spi_request_action), 32'd1);
        @(negedge clk);
        spi_busy = 1'b1;
        @(negedge clk);
        reset    = 1'b1;
        spi_busy = 1'b0;
        req      = '0;
        @(negedge clk);
        checkOutput("midRstGrant", 32'(grant), 32'd0);
        checkOutput("midRstDone", 32'(done), 32'd0);
        checkOutput("midRstAction", 32'(spi_request_action), 32'd0);
        checkOutput("midRstSpiData", spi_data_out, 32'd0);
        checkOutput("midRstRdData", rd_data, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midRstNoDone", 32'(done), 32'd0);
        modelPtr = 0;
        applyStimulus(4'b1111, 0, 1, 2, $urandom(), 1'b1);

`ifdef SPI_ARB_TIMEOUT_EN
        prevRd = rd_data;
        req    = 4'b0011;
        tw     = rrPick(req, modelPtr);
        waitCnt = 0;
        do begin
            @(negedge clk);
            waitCnt++;
        end while (spi_request_action !== 1'b1 && waitCnt < 8);
        checkOutput("tmoLaunch", 32'(spi_request_action), 32'd1);
        waitCnt = 0;
        do begin
            @(negedge clk);
            waitCnt++;
        end while (done === '0 && waitCnt < 40);
        checkOutput("tmoLatency", 32'(waitCnt), 32'(TMO + 1));
        checkOutput("tmoDone", 32'(done), 32'd1 << tw);
        checkOutput("tmoErr", 32'(err), 32'd1);
        checkOutput("tmoRdKept", rd_data, prevRd);
        req[tw]  = 1'b0;
        modelPtr = (tw + 1) % N;
        @(negedge clk);
        checkOutput("tmoErrCleared", 32'(err), 32'd0);
        applyStimulus(req, 0, 1, 2, $urandom(), 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time budget exhausted");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin arbiter that shares the single `spi_interface` SPI master between up to NUM_REQ register-access agents (ADC configuration, clock-chip setup, DAQ housekeeping). Each agent presents a complete transaction (payload plus read/write bit counts); the arbiter grants one agent at a time, launches the transfer on `spi_interface`, tracks its `busy` handshake, and returns read data with a one-cycle completion strobe. It sits between the agents and `spi_interface`, in the slow SPI clock domain.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles (used only with SPI_ARB_TIMEOUT_EN)

Ports:
- clk  input  1  SPI-domain clock; all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state
- req  input  NUM_REQ  per-agent request level; held high until matching done
- req_data_out  input  NUM_REQ*32  agent i payload at bits [32*i+31:32*i]
- req_read_bits  input  NUM_REQ*6  agent i read bit count at [6*i+5:6*i]
- req_write_bits  input  NUM_REQ*6  agent i write bit count at [6*i+5:6*i]
- grant  output  NUM_REQ  one-hot, high from grant to done inclusive
- done  output  NUM_REQ  one-cycle strobe to the serviced agent
- rd_data  output  32  captured `spi_data_in`, valid on done strobe, held until next done
- err  output  1  one-cycle strobe alongside done when transaction aborted (timeout)
- spi_data_out  output  32  muxed payload to spi_interface
- spi_read_bits  output  6  muxed read count
- spi_write_bits  output  6  muxed write count
- spi_request_action  output  1  one-cycle launch pulse
- spi_busy  input  1  spi_interface busy
- spi_data_in  input  32  spi_interface read data

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, COMPLETE.
- IDLE: if req != 0 and spi_busy == 0, select winner by round-robin starting at index ptr; register grant, latch winner's payload/counts into spi_* outputs; -> LAUNCH. If spi_busy == 1, stay.
- LAUNCH: spi_request_action = 1 for exactly this cycle; -> WAIT_BUSY.
- WAIT_BUSY: wait for spi_busy == 1; -> WAIT_DONE.
- WAIT_DONE: wait for spi_busy == 0; capture spi_data_in into rd_data; -> COMPLETE.
- COMPLETE: done[winner] = 1, grant cleared; ptr <= (winner+1) mod NUM_REQ; -> IDLE.
- spi_* payload/count outputs stay latched from IDLE-exit until next grant; agent input changes after grant are ignored.
- req[winner] dropping mid-transaction does not abort; transfer completes and done still pulses.
- Requests arriving while busy wait; no queueing beyond the level req.
- ptr wraps NUM_REQ-1 -> 0; ptr starts at 0 after reset.

## Timing
- Reset values: grant=0, done=0, rd_data=0, err=0, spi_data_out=0, spi_read_bits=0, spi_write_bits=0, spi_request_action=0, state=IDLE, ptr=0.
- req high in IDLE at cycle T -> grant high T+1, spi_request_action high T+1 (LAUNCH) only, T+2 onward in WAIT_BUSY.
- done strobes the cycle after spi_busy is sampled low in WAIT_DONE; rd_data valid that same cycle.
- Minimum one IDLE cycle between transactions; back-to-back service of two agents takes ≥ 1 idle cycle.
- Reset asserted mid-transaction: next cycle all outputs at reset values; no done pulse; spi_interface is reset by the same signal.

## Configuration
- SPI_ARB_TIMEOUT_EN defined: a counter runs in WAIT_BUSY and WAIT_DONE; on reaching TIMEOUT_CYCLES, -> COMPLETE with done[winner]=1, err=1, rd_data unchanged; ptr advances as normal.
- Not defined: no counter, err tied 0; arbiter waits indefinitely on spi_busy.

## Test plan
- Single request: req=4'b0010, req_data_out[63:32]=32'h03F0_0010, spi_busy high 3 cycles after launch, spi_data_in=32'hA5 -> one request_action pulse, spi_data_out=32'h03F0_0010, done=4'b0010, rd_data=32'hA5.
- Fairness: req=4'b1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
- Wrap: ptr=3 after serving agent 2, req=4'b0001 -> grant 0; then req=4'b1001 -> agent 3 before 0 only if ptr=1.. verify agent 3 served next, then 0.
- Payload change after grant: alter req_data_out of granted agent during WAIT_DONE -> spi_data_out unchanged.
- Reset in WAIT_DONE -> next cycle grant=0, done=0, state IDLE; subsequent req serviced normally with ptr=0.
- With SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, spi_busy never asserts -> done and err strobe 17 cycles after LAUNCH; next agent then granted.
